id_stage_reg: RTL and testbench
===============================

Name: id_stage_reg

Overview:
Parametrised successor of the ARM decode stage. It combines decode, condition check, register-file read with write-back bypass, and the ID/EX pipeline register in one block. Decoded fields and operands are registered at the clock edge. Stall (bubble insertion) and flush are handled internally, so EXE sees clean bubbles. It sits between the IF/ID register and the EXE stage, and feeds source indices combinationally to the hazard unit.

Parameters:
BIT_NUMBER, 32, datapath and register width
REG_NUM_BITS, 4, register index width; register file depth is 2**REG_NUM_BITS
SR_BITS, 4, status register width, ordered {N,Z,C,V}

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  IF/ID holds a valid instruction
instruction  in  BIT_NUMBER  instruction from IF/ID
pc_in  in  BIT_NUMBER  PC+4 of that instruction
hazard  in  1  hazard unit stall request
flush  in  1  taken branch; kill the instruction in ID
sr  in  SR_BITS  status register {N,Z,C,V}
write_back_en  in  1  WB write enable
dest_wb  in  REG_NUM_BITS  WB destination index
result_wb  in  BIT_NUMBER  WB data
first_src  out  REG_NUM_BITS  comb: instruction[19:16] (Rn)
second_src  out  REG_NUM_BITS  comb: Rd if decoded store, else Rm (instruction[3:0])
two_src  out  1  comb: ~instruction[25] | decoded store
out_valid  out  1  reg: EXE slot holds a live instruction
pc_out  out  BIT_NUMBER  reg
wb_en, mem_r_en, mem_w_en, b, s, imm  out  1 each  reg
exe_cmd  out  4  reg
dest  out  REG_NUM_BITS  reg: Rd
shift_operand  out  12  reg: instruction[11:0]
signed_imm_24  out  24  reg: instruction[23:0]
val_rn, val_rm  out  BIT_NUMBER  reg: operand values

Behaviour:
- Clocking: one clock; reset synchronous, active-high. All registered outputs are 0 after a reset edge, and every register-file entry is 0.
- Field split: cond [31:28], mode [27:26], I [25], opcode [24:21], S [20], Rn [19:16], Rd [15:12], Rm [3:0].
- Decode table, mode 00 (wb_en=1 unless noted):
  - MOV 1101→0001; MVN 1111→1001
  - ADD 0100→0010; ADC 0101→0011
  - SUB 0010→0100; SBC 0110→0101
  - AND 0000→0110; ORR 1100→0111; EOR 0001→1000
  - CMP 1010→0100, wb_en=0
  - TST 1000→0110, wb_en=0
  - Any other opcode: all controls 0.
  - s = S bit.
- Decode table, mode 01:
  - S=1 is LDR: exe_cmd=0010, mem_r_en=1, wb_en=1, s=0.
  - S=0 is STR: exe_cmd=0010, mem_w_en=1, wb_en=0, s=0.
- Decode table, mode 10: b=1, all other controls 0. Mode 11: all controls 0.
- Condition check (standard ARM): EQ/NE on Z; CS/CC on C; MI/PL on N; VS/VC on V; HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V); AL 1110 → pass; 1111 → fail.
- Register file:
  - Write on rising edge when write_back_en=1, independent of stall and flush; blocked only by rst.
  - Reads are combinational with write-first bypass: if write_back_en and the read index equals dest_wb, the value read is result_wb.
- Pipeline register update, priority rst > flush > hazard > normal:
  - flush: out_valid and all control bits ← 0; data fields are don't-care.
  - hazard: insert a bubble (out_valid and controls ← 0). The instruction is held upstream and re-decoded when hazard drops.
  - normal: latch all fields. out_valid ← in_valid & cond_pass. Control bits latch only if in_valid & cond_pass, else 0.
- Latency: exactly one cycle from ID to the registered outputs. No combinational path from hazard or flush to registered outputs.
- Simultaneous WB write and read of the same register latches the new value.
- Reset asserted mid-stream clears all in-flight state at that edge.

Test Plan:
- Reset: hold rst 2 cycles with arbitrary inputs → all registered outputs 0; register file reads 0.
- ADD R1,R2,R3 (0xE0821003), in_valid=1, same-cycle WB R2←5 (R3 previously written 9) → next cycle out_valid=1, exe_cmd=0010, wb_en=1, dest=1, val_rn=5 (bypass), val_rm=9, two_src=1.
- MOVS R0,#7 (0xE3B00007) → imm=1, s=1, exe_cmd=0001, two_src=0, shift_operand=0x007.
- STR R1,[R2,#4] (0xE5821004) → second_src=1, two_src=1, mem_w_en=1, wb_en=0, exe_cmd=0010. Follow with B (0xEA000010) → b=1, signed_imm_24=0x000010.
- Condition fail: 0x00821003 with sr=0000 (Z=0) → out_valid=0, all controls 0. Same instruction with sr=0100 → out_valid=1.
- hazard=1 for 2 cycles on ADD, then 0 → two bubbles, then ADD issues once. flush and hazard together → bubble. rst and flush together → reset values.

Source files
------------

// File: rtl/id_stage_reg.sv
// id_stage_reg: decode, condition check, register file with write-back bypass, and the
// ID/EX pipeline register in one block.
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   in_valid, instruction,      instruction from IF/ID and its PC+4
//   pc_in
//   hazard, flush               stall request (bubble), taken-branch kill
//   sr                          status flags {N,Z,C,V}
//   write_back_en, dest_wb,     write-back port of the register file
//   result_wb
//   first_src, second_src,      combinational source indices for the hazard unit
//   two_src
//   out_valid ... val_rm        registered ID/EX fields seen by EXE
module id_stage_reg #(
    parameter int BIT_NUMBER   = 32,
    parameter int REG_NUM_BITS = 4,
    parameter int SR_BITS      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [BIT_NUMBER-1:0]   instruction,
    input  logic [BIT_NUMBER-1:0]   pc_in,
    input  logic                    hazard,
    input  logic                    flush,
    input  logic [SR_BITS-1:0]      sr,
    input  logic                    write_back_en,
    input  logic [REG_NUM_BITS-1:0] dest_wb,
    input  logic [BIT_NUMBER-1:0]   result_wb,
    output logic [REG_NUM_BITS-1:0] first_src,
    output logic [REG_NUM_BITS-1:0] second_src,
    output logic                    two_src,
    output logic                    out_valid,
    output logic [BIT_NUMBER-1:0]   pc_out,
    output logic                    wb_en,
    output logic                    mem_r_en,
    output logic                    mem_w_en,
    output logic                    b,
    output logic                    s,
    output logic                    imm,
    output logic [3:0]              exe_cmd,
    output logic [REG_NUM_BITS-1:0] dest,
    output logic [11:0]             shift_operand,
    output logic [23:0]             signed_imm_24,
    output logic [BIT_NUMBER-1:0]   val_rn,
    output logic [BIT_NUMBER-1:0]   val_rm
);

    localparam int RegDepth = 2 ** REG_NUM_BITS;

    // Instruction fields
    logic [3:0]              cond;
    logic [1:0]              mode;
    logic                    i_bit;
    logic [3:0]              opcode;
    logic                    s_bit;
    logic [REG_NUM_BITS-1:0] rn, rd, rm;

    assign cond   = instruction[31:28];
    assign mode   = instruction[27:26];
    assign i_bit  = instruction[25];
    assign opcode = instruction[24:21];
    assign s_bit  = instruction[20];
    assign rn     = REG_NUM_BITS'(instruction[19:16]);
    assign rd     = REG_NUM_BITS'(instruction[15:12]);
    assign rm     = REG_NUM_BITS'(instruction[3:0]);

    // Decode
    logic       dec_wb, dec_mr, dec_mw, dec_b, dec_s;
    logic [3:0] dec_cmd;
    logic       is_store;

    assign is_store = (mode == 2'b01) && !s_bit;

    always_comb begin
        dec_wb  = 1'b0;
        dec_mr  = 1'b0;
        dec_mw  = 1'b0;
        dec_b   = 1'b0;
        dec_s   = 1'b0;
        dec_cmd = 4'b0000;
        unique case (mode)
            2'b00: begin
                // Recognised ALU ops write back and honour S; unknown opcodes decode to nothing.
                dec_wb = 1'b1;
                dec_s  = s_bit;
                unique case (opcode)
                    4'b1101: dec_cmd = 4'b0001; // MOV
                    4'b1111: dec_cmd = 4'b1001; // MVN
                    4'b0100: dec_cmd = 4'b0010; // ADD
                    4'b0101: dec_cmd = 4'b0011; // ADC
                    4'b0010: dec_cmd = 4'b0100; // SUB
                    4'b0110: dec_cmd = 4'b0101; // SBC
                    4'b0000: dec_cmd = 4'b0110; // AND
                    4'b1100: dec_cmd = 4'b0111; // ORR
                    4'b0001: dec_cmd = 4'b1000; // EOR
                    4'b1010: begin              // CMP
                        dec_cmd = 4'b0100;
                        dec_wb  = 1'b0;
                    end
                    4'b1000: begin              // TST
                        dec_cmd = 4'b0110;
                        dec_wb  = 1'b0;
                    end
                    default: begin
                        dec_wb = 1'b0;
                        dec_s  = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                // LDR when S=1, STR when S=0; address always computed by ADD
                dec_cmd = 4'b0010;
                dec_mr  = s_bit;
                dec_wb  = s_bit;
                dec_mw  = !s_bit;
            end
            2'b10: dec_b = 1'b1;
            default: ;
        endcase
    end

    // Condition check
    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_pass;

    assign flag_n = sr[3];
    assign flag_z = sr[2];
    assign flag_c = sr[1];
    assign flag_v = sr[0];

    always_comb begin
        cond_pass = 1'b0;
        unique case (cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = !flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = !flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = !flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = !flag_v;
            4'b1000: cond_pass = flag_c && !flag_z;
            4'b1001: cond_pass = !flag_c || flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
            4'b1101: cond_pass = flag_z || (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Hazard-unit view
    assign first_src  = rn;
    assign second_src = is_store ? rd : rm;
    assign two_src    = !i_bit || is_store;

    // Register file, write-first bypass on reads
    logic [BIT_NUMBER-1:0] rf_q [RegDepth];
    logic [BIT_NUMBER-1:0] rd_rn, rd_rm;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RegDepth; i++) rf_q[i] <= '0;
        end else if (write_back_en) begin
            rf_q[dest_wb] <= result_wb;
        end
    end

    assign rd_rn = (write_back_en && dest_wb == first_src)  ? result_wb : rf_q[first_src];
    assign rd_rm = (write_back_en && dest_wb == second_src) ? result_wb : rf_q[second_src];

    // ID/EX register. Flush and hazard only gate the D side; data fields latch regardless.
    logic issue;
    assign issue = in_valid && cond_pass && !flush && !hazard;

    logic                    valid_q, wb_q, mr_q, mw_q, b_q, s_q, imm_q;
    logic [3:0]              cmd_q;
    logic [BIT_NUMBER-1:0]   pc_q, rn_val_q, rm_val_q;
    logic [REG_NUM_BITS-1:0] dest_q;
    logic [11:0]             shift_q;
    logic [23:0]             imm24_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            wb_q     <= 1'b0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
            b_q      <= 1'b0;
            s_q      <= 1'b0;
            imm_q    <= 1'b0;
            cmd_q    <= 4'b0000;
            pc_q     <= '0;
            rn_val_q <= '0;
            rm_val_q <= '0;
            dest_q   <= '0;
            shift_q  <= '0;
            imm24_q  <= '0;
        end else begin
            valid_q  <= issue;
            wb_q     <= issue && dec_wb;
            mr_q     <= issue && dec_mr;
            mw_q     <= issue && dec_mw;
            b_q      <= issue && dec_b;
            s_q      <= issue && dec_s;
            imm_q    <= issue && i_bit;
            cmd_q    <= issue ? dec_cmd : 4'b0000;
            pc_q     <= pc_in;
            rn_val_q <= rd_rn;
            rm_val_q <= rd_rm;
            dest_q   <= rd;
            shift_q  <= instruction[11:0];
            imm24_q  <= instruction[23:0];
        end
    end

    assign out_valid     = valid_q;
    assign wb_en         = wb_q;
    assign mem_r_en      = mr_q;
    assign mem_w_en      = mw_q;
    assign b             = b_q;
    assign s             = s_q;
    assign imm           = imm_q;
    assign exe_cmd       = cmd_q;
    assign pc_out        = pc_q;
    assign dest          = dest_q;
    assign shift_operand = shift_q;
    assign signed_imm_24 = imm24_q;
    assign val_rn        = rn_val_q;
    assign val_rm        = rm_val_q;

endmodule

// File: tb/tb_id_stage_reg.sv
module tb_id_stage_reg;

    logic        clk = 1'b0;
    logic        rst, in_valid, hazard, flush, write_back_en;
    logic [31:0] instruction, pc_in, result_wb;
    logic [3:0]  sr, dest_wb;
    logic [3:0]  first_src, second_src;
    logic        two_src, out_valid, wb_en, mem_r_en, mem_w_en, b, s, imm;
    logic [3:0]  exe_cmd, dest;
    logic [31:0] pc_out, val_rn, val_rm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;

    always #5 clk = ~clk;

    id_stage_reg #(.BIT_NUMBER(32), .REG_NUM_BITS(4), .SR_BITS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction), .pc_in(pc_in),
        .hazard(hazard), .flush(flush), .sr(sr), .write_back_en(write_back_en),
        .dest_wb(dest_wb), .result_wb(result_wb), .first_src(first_src),
        .second_src(second_src), .two_src(two_src), .out_valid(out_valid), .pc_out(pc_out),
        .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .b(b), .s(s), .imm(imm),
        .exe_cmd(exe_cmd), .dest(dest), .shift_operand(shift_operand),
        .signed_imm_24(signed_imm_24), .val_rn(val_rn), .val_rm(val_rm)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference state: architectural register file and ALU opcode table
    logic [31:0] mregs   [16];
    logic [3:0]  alu_cmd [16];
    logic        alu_wb  [16];

    typedef struct packed {
        logic       wb, mr, mw, br, sf;
        logic [3:0] cmd;
    } ctl_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Odd codes are the negation of the even code below them; 1110 always, 1111 never.
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic nf, zf, cf, vf, base;
        nf = f[3]; zf = f[2]; cf = f[1]; vf = f[0];
        if (c == 4'hE) return 1'b1;
        if (c == 4'hF) return 1'b0;
        case (c / 2)
            0: base = zf;
            1: base = cf;
            2: base = nf;
            3: base = vf;
            4: base = cf && !zf;
            5: base = (nf == vf);
            default: base = !zf && (nf == vf);
        endcase
        return (c % 2 == 1) ? !base : base;
    endfunction

    function automatic ctl_t decode(input logic [31:0] ins);
        ctl_t r;
        logic [1:0] md;
        logic [3:0] op;
        r  = '0;
        md = ins[27:26];
        op = ins[24:21];
        if (md == 2'd0 && alu_cmd[op] != 4'd0) begin
            r.cmd = alu_cmd[op];
            r.wb  = alu_wb[op];
            r.sf  = ins[20];
        end else if (md == 2'd1) begin
            r.cmd = 4'd2;
            r.mr  = ins[20];
            r.wb  = ins[20];
            r.mw  = !ins[20];
        end else if (md == 2'd2) begin
            r.br = 1'b1;
        end
        return r;
    endfunction

    task automatic drive(input logic [31:0] ins, input logic v, input logic h, input logic f,
                         input logic [3:0] flags, input logic we, input logic [3:0] dw,
                         input logic [31:0] res);
        instruction   = ins;
        in_valid      = v;
        hazard        = h;
        flush         = f;
        sr            = flags;
        write_back_en = we;
        dest_wb       = dw;
        result_wb     = res;
        pc_in         = $urandom;
    endtask

    // Check combinational outputs, clock once, update the model and check registered outputs.
    task automatic step();
        ctl_t        d, got;
        logic        st, iss, r_now, normal, ib;
        logic [3:0]  rn, rd, src2;
        logic [31:0] e_rn, e_rm, pc_e, ins;
        #1;
        ins  = instruction;
        rn   = ins[19:16];
        rd   = ins[15:12];
        st   = (ins[27:26] == 2'd1) && !ins[20];
        src2 = st ? rd : ins[3:0];
        ib   = ins[25];
        chk("first_src", 32'(first_src), 32'(rn));
        chk("second_src", 32'(second_src), 32'(src2));
        chk("two_src", 32'(two_src), 32'(!ib || st));
        e_rn   = (write_back_en && dest_wb == rn)   ? result_wb : mregs[rn];
        e_rm   = (write_back_en && dest_wb == src2) ? result_wb : mregs[src2];
        d      = decode(ins);
        r_now  = rst;
        iss    = in_valid && cond_ok(ins[31:28], sr) && !flush && !hazard;
        normal = !rst && !flush && !hazard;
        pc_e   = pc_in;
        @(posedge clk);
        #1;
        if (r_now) begin
            for (int i = 0; i < 16; i++) mregs[i] = '0;
        end else if (write_back_en) begin
            mregs[dest_wb] = result_wb;
        end
        got = {wb_en, mem_r_en, mem_w_en, b, s, exe_cmd};
        if (r_now) begin
            chk("rst_ctl", 32'(got), 32'(0));
            chk("rst_valid_imm", 32'({out_valid, imm}), 32'(0));
            chk("rst_data", pc_out | val_rn | val_rm | 32'(dest) | 32'(shift_operand)
                | 32'(signed_imm_24), 32'(0));
        end else begin
            chk("out_valid", 32'(out_valid), 32'(iss));
            chk("ctl", 32'(got), iss ? 32'(d) : 32'(0));
            chk("imm", 32'(imm), 32'(iss && ib));
            if (normal) begin
                chk("pc_out", pc_out, pc_e);
                chk("dest", 32'(dest), 32'(rd));
                chk("shift_operand", 32'(shift_operand), 32'(ins[11:0]));
                chk("signed_imm_24", 32'(signed_imm_24), 32'(ins[23:0]));
                chk("val_rn", val_rn, e_rn);
                chk("val_rm", val_rm, e_rm);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            alu_cmd[i] = 4'd0;
            alu_wb[i]  = 1'b1;
            mregs[i]   = 32'hDEAD_BEEF;
        end
        alu_cmd[4'hD] = 4'd1;  alu_cmd[4'hF] = 4'd9;
        alu_cmd[4'h4] = 4'd2;  alu_cmd[4'h5] = 4'd3;
        alu_cmd[4'h2] = 4'd4;  alu_cmd[4'h6] = 4'd5;
        alu_cmd[4'h0] = 4'd6;  alu_cmd[4'hC] = 4'd7;
        alu_cmd[4'h1] = 4'd8;
        alu_cmd[4'hA] = 4'd4;  alu_wb[4'hA] = 1'b0;
        alu_cmd[4'h8] = 4'd6;  alu_wb[4'h8] = 1'b0;

        // Reset with arbitrary inputs
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive($urandom, 1'b1, 1'($urandom), 1'($urandom), 4'($urandom), 1'b1,
                  4'($urandom), $urandom);
            step();
        end
        rst = 1'b0;

        // R3 <- 9 while ID is empty; R2 still reads its reset value
        drive(32'hE082_1003, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'd3, 32'd9);
        step();
        chk("rf_reset_read", val_rn, 32'd0);

        // ADD R1,R2,R3 with R2 <- 5 in the same cycle
        drive(32'hE082_1003, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'd2, 32'd5);
        step();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_cmd", 32'(exe_cmd), 32'd2);
        chk("add_dest", 32'(dest), 32'd1);
        chk("add_bypass_rn", val_rn, 32'd5);
        chk("add_rm", val_rm, 32'd9);

        // MOVS R0,#7
        drive(32'hE3B0_0007, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'd0, 32'd0);
        step();
        chk("movs_imm_s", 32'({imm, s}), 32'd3);
        chk("movs_cmd", 32'(exe_cmd), 32'd1);
        chk("movs_shift", 32'(shift_operand), 32'h007);

        // STR R1,[R2,#4] then B
        drive(32'hE582_1004, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'd0, 32'd0);
        step();
        chk("str_mem_w", 32'({mem_w_en, wb_en}), 32'b10);
        drive(32'hEA00_0010, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'd0, 32'd0);
        step();
        chk("b_bit", 32'(b), 32'd1);
        chk("b_imm24", 32'(signed_imm_24), 32'h10);

        // EQ condition: fails with Z=0, passes with Z=1
        drive(32'h0082_1003, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd0, 32'd0);
        step();
        chk("eq_fail_valid", 32'(out_valid), 32'd0);
        drive(32'h0082_1003, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 4'd0, 32'd0);
        step();
        chk("eq_pass_valid", 32'(out_valid), 32'd1);

        // Two hazard cycles, then the ADD issues exactly once
        for (int k = 0; k < 2; k++) begin
            drive(32'hE082_1003, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'd0, 32'd0);
            step();
            chk("hazard_bubble", 32'(out_valid), 32'd0);
        end
        drive(32'hE082_1003, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'd0, 32'd0);
        step();
        chk("hazard_release", 32'(out_valid), 32'd1);
        drive(32'hE082_1003, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'd0, 32'd0);
        step();
        chk("issued_once", 32'(out_valid), 32'd0);

        // flush with hazard, then rst with flush
        drive(32'hE082_1003, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 4'd0, 32'd0);
        step();
        chk("flush_hazard_bubble", 32'(out_valid), 32'd0);
        rst = 1'b1;
        drive(32'hE082_1003, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 4'd5, 32'd77);
        step();
        rst = 1'b0;

        // Randomised traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            logic [31:0] ins;
            ins = $urandom;
            if ($urandom_range(1, 0) == 1) ins[31:28] = 4'hE;
            rst = ($urandom_range(99, 0) < 3);
            drive(ins, ($urandom_range(9, 0) < 8), ($urandom_range(9, 0) < 2),
                  ($urandom_range(9, 0) < 1), 4'($urandom), 1'($urandom), 4'($urandom),
                  $urandom);
            step();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
